// File: rtl/control_sequencer.sv
// control_sequencer: five-step (T0..T4) microcode sequencer for a simple
// 8-bit bus machine. Control strobes are decoded combinationally from the
// current step, the opcode and the ALU flags. HLT parks the sequencer in a
// HALTED state until reset.
// Optional feature: define CONDITIONAL_JUMP_EN to enable JMP/JC/JZ.
// Without it, those opcodes decode as NOP and cf/zf are ignored.
module control_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       cf,
    input  logic       zf,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_load,
    output logic       ram_out,
    output logic       ir_load,
    output logic       ir_out,
    output logic       a_load,
    output logic       a_out,
    output logic       b_load,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       flags_load,
    output logic       out_load,
    output logic       halt,
    output logic [2:0] t_state
);

    typedef enum logic [2:0] {
        ST_T0     = 3'd0,
        ST_T1     = 3'd1,
        ST_T2     = 3'd2,
        ST_T3     = 3'd3,
        ST_T4     = 3'd4,
        ST_HALTED = 3'd5
    } state_t;

    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;
`ifdef CONDITIONAL_JUMP_EN
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
`endif

    state_t r_state;
    state_t w_next;
    logic   w_jumpTaken;

`ifdef CONDITIONAL_JUMP_EN
    // Jump condition: unconditional JMP, or JC/JZ when the matching flag is set
    always_comb begin
        w_jumpTaken = (opcode == OP_JMP) ||
                      ((opcode == OP_JC) && cf) ||
                      ((opcode == OP_JZ) && zf);
    end
`else
    logic w_unusedFlags;
    assign w_unusedFlags = cf ^ zf;
    assign w_jumpTaken   = 1'b0;
`endif

    // State register; synchronous reset always returns to T0 (also from HALTED)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_T0;
        end else begin
            r_state <= w_next;
        end
    end

    // Next step: free-running ring of five steps, HLT diverts to HALTED at end of T2
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_T0:     w_next = ST_T1;
            ST_T1:     w_next = ST_T2;
            ST_T2:     w_next = (opcode == OP_HLT) ? ST_HALTED : ST_T3;
            ST_T3:     w_next = ST_T4;
            ST_T4:     w_next = ST_T0;
            ST_HALTED: w_next = ST_HALTED;
            default:   w_next = ST_T0;
        endcase
    end

    // Strobe decode; everything is forced low while reset is asserted
    always_comb begin
        pc_out     = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        mar_load   = 1'b0;
        ram_out    = 1'b0;
        ir_load    = 1'b0;
        ir_out     = 1'b0;
        a_load     = 1'b0;
        a_out      = 1'b0;
        b_load     = 1'b0;
        alu_out    = 1'b0;
        alu_sub    = 1'b0;
        flags_load = 1'b0;
        out_load   = 1'b0;
        halt       = 1'b0;
        t_state    = (r_state == ST_HALTED) ? 3'd2 : 3'(r_state);
        if (rst_n) begin
            case (r_state)
                ST_T0: begin
                    pc_out   = 1'b1;
                    mar_load = 1'b1;
                end
                ST_T1: begin
                    ram_out = 1'b1;
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                end
                ST_T2: begin
                    if ((opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        ir_out   = 1'b1;
                        mar_load = 1'b1;
                    end else if (opcode == OP_OUT) begin
                        a_out    = 1'b1;
                        out_load = 1'b1;
                    end else if (w_jumpTaken) begin
                        ir_out  = 1'b1;
                        pc_load = 1'b1;
                    end
                end
                ST_T3: begin
                    if (opcode == OP_LDA) begin
                        ram_out = 1'b1;
                        a_load  = 1'b1;
                    end else if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        ram_out = 1'b1;
                        b_load  = 1'b1;
                        alu_sub = (opcode == OP_SUB);
                    end
                end
                ST_T4: begin
                    if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        alu_out    = 1'b1;
                        a_load     = 1'b1;
                        flags_load = 1'b1;
                        alu_sub    = (opcode == OP_SUB);
                    end
                end
                ST_HALTED: begin
                    halt = 1'b1;
                end
                default: begin
                    halt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed plus randomized checking of control_sequencer
// against a behavioural model built from the instruction/step strobe table.
module tb_control_sequencer;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic       cf;
    logic       zf;
    logic       pc_out, pc_inc, pc_load, mar_load, ram_out, ir_load, ir_out;
    logic       a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load;
    logic       halt;
    logic [2:0] t_state;

    // Bit positions of each strobe in the packed comparison vector
    localparam int S_PC_OUT   = 13;
    localparam int S_PC_INC   = 12;
    localparam int S_PC_LOAD  = 11;
    localparam int S_MAR_LOAD = 10;
    localparam int S_RAM_OUT  = 9;
    localparam int S_IR_LOAD  = 8;
    localparam int S_IR_OUT   = 7;
    localparam int S_A_LOAD   = 6;
    localparam int S_A_OUT    = 5;
    localparam int S_B_LOAD   = 4;
    localparam int S_ALU_OUT  = 3;
    localparam int S_ALU_SUB  = 2;
    localparam int S_FLAGS    = 1;
    localparam int S_OUT_LOAD = 0;

    int checks = 0;
    int errors = 0;

    // Behavioural model: instruction step 0..4 and halted flag
    int mStep   = 0;
    bit mHalted = 1'b0;

    control_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .cf         (cf),
        .zf         (zf),
        .pc_out     (pc_out),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .mar_load   (mar_load),
        .ram_out    (ram_out),
        .ir_load    (ir_load),
        .ir_out     (ir_out),
        .a_load     (a_load),
        .a_out      (a_out),
        .b_load     (b_load),
        .alu_out    (alu_out),
        .alu_sub    (alu_sub),
        .flags_load (flags_load),
        .out_load   (out_load),
        .halt       (halt),
        .t_state    (t_state)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected strobes from the instruction table for a given step/opcode/flags
    function automatic logic [13:0] expStrobes(int step, bit halted, logic [3:0] op,
                                               bit c, bit z, bit rstn);
        logic [13:0] v;
        v = '0;
        if (!rstn || halted) return v;
        if (step == 0) begin
            v[S_PC_OUT] = 1'b1; v[S_MAR_LOAD] = 1'b1;
        end else if (step == 1) begin
            v[S_RAM_OUT] = 1'b1; v[S_IR_LOAD] = 1'b1; v[S_PC_INC] = 1'b1;
        end else begin
            case (op)
                4'd1: begin
                    if (step == 2) begin v[S_IR_OUT] = 1'b1; v[S_MAR_LOAD] = 1'b1; end
                    if (step == 3) begin v[S_RAM_OUT] = 1'b1; v[S_A_LOAD] = 1'b1; end
                end
                4'd2, 4'd3: begin
                    if (step == 2) begin v[S_IR_OUT] = 1'b1; v[S_MAR_LOAD] = 1'b1; end
                    if (step == 3) begin v[S_RAM_OUT] = 1'b1; v[S_B_LOAD] = 1'b1; end
                    if (step == 4) begin
                        v[S_ALU_OUT] = 1'b1; v[S_A_LOAD] = 1'b1; v[S_FLAGS] = 1'b1;
                    end
                    if (op == 4'd3 && step >= 3) v[S_ALU_SUB] = 1'b1;
                end
                4'd14: begin
                    if (step == 2) begin v[S_A_OUT] = 1'b1; v[S_OUT_LOAD] = 1'b1; end
                end
`ifdef CONDITIONAL_JUMP_EN
                4'd6, 4'd7, 4'd8: begin
                    if (step == 2 && (op == 4'd6 || (op == 4'd7 && c) || (op == 4'd8 && z))) begin
                        v[S_IR_OUT] = 1'b1; v[S_PC_LOAD] = 1'b1;
                    end
                end
`endif
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    // Drive all inputs for the coming cycle
    task automatic applyStimulus(input logic [3:0] op, input bit c, input bit z, input bit rstn);
        opcode = op;
        cf     = c;
        zf     = z;
        rst_n  = rstn;
    endtask

    // Compare DUT outputs with the model (called on the falling edge)
    task automatic checkOutput(input string tag);
        logic [13:0] obs;
        logic [13:0] exp;
        logic [4:0]  bus;
        logic [2:0]  expT;
        logic        expHalt;
        obs = {pc_out, pc_inc, pc_load, mar_load, ram_out, ir_load, ir_out,
               a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load};
        exp = expStrobes(mStep, mHalted, opcode, cf, zf, rst_n);
        expHalt = rst_n && mHalted;
        expT = mHalted ? 3'd2 : 3'(mStep);
        bus = {pc_out, ram_out, ir_out, a_out, alu_out};

        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s strobes: got %b expected %b", tag, obs, exp);
        end
        checks++;
        assert (halt === expHalt) else begin
            errors++;
            $error("FAIL %s halt: got %b expected %b", tag, halt, expHalt);
        end
        checks++;
        assert (t_state === expT) else begin
            errors++;
            $error("FAIL %s t_state: got %0d expected %0d", tag, t_state, expT);
        end
        checks++;
        assert (($countones(bus) <= 1) === 1'b1) else begin
            errors++;
            $error("FAIL %s bus_onehot: got %b expected at most one driver", tag, bus);
        end
        checks++;
        assert ((pc_inc & pc_load) === 1'b0) else begin
            errors++;
            $error("FAIL %s pc_excl: got %b expected 0", tag, pc_inc & pc_load);
        end
    endtask

    // Advance the model by one rising edge using the inputs in force
    task automatic modelStep();
        if (!rst_n) begin
            mStep   = 0;
            mHalted = 1'b0;
        end else if (!mHalted) begin
            if (mStep == 2 && opcode == 4'hF) mHalted = 1'b1;
            else mStep = (mStep + 1) % 5;
        end
    endtask

    // One full cycle: drive, check on falling edge, advance on rising edge
    task automatic runCycle(input logic [3:0] op, input bit c, input bit z,
                            input bit rstn, input string tag);
        applyStimulus(op, c, z, rstn);
        @(negedge clk);
        checkOutput(tag);
        @(posedge clk);
        modelStep();
        #1;
    endtask

    initial begin
        // Bring the DUT into a known state before the first comparison
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        mStep   = 0;
        mHalted = 1'b0;
        #1;

        // Reset held two cycles, then LDA through a full instruction
        runCycle(4'h1, 1'b0, 1'b0, 1'b0, "rst0");
        runCycle(4'h1, 1'b0, 1'b0, 1'b0, "rst1");
        for (int i = 0; i < 6; i++) runCycle(4'h1, 1'b0, 1'b0, 1'b1, "lda");

        // SUB instruction, flags toggling
        for (int i = 0; i < 5; i++) runCycle(4'h3, 1'(i), 1'(i >> 1), 1'b1, "sub");
        // ADD and OUT instructions
        for (int i = 0; i < 5; i++) runCycle(4'h2, 1'b1, 1'b1, 1'b1, "add");
        for (int i = 0; i < 5; i++) runCycle(4'hE, 1'b0, 1'b1, 1'b1, "out");

        // HLT then 20 halted cycles with wandering inputs, then 1-cycle reset
        for (int i = 0; i < 3; i++) runCycle(4'hF, 1'b0, 1'b0, 1'b1, "hlt");
        for (int i = 0; i < 20; i++)
            runCycle(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'b1, "halted");
        runCycle(4'h1, 1'b0, 1'b0, 1'b0, "hlt_rst");
        runCycle(4'h1, 1'b0, 1'b0, 1'b1, "after_hlt");

        // Reset asserted during T3 of ADD
        for (int i = 0; i < 4; i++) runCycle(4'h2, 1'b0, 1'b0, 1'b1, "add_pre");
        for (int i = 0; i < 3; i++) runCycle(4'h2, 1'b0, 1'b0, 1'b1, "add_mid");
        runCycle(4'h2, 1'b0, 1'b0, 1'b0, "add_rst_t3");
        runCycle(4'h2, 1'b0, 1'b0, 1'b0, "add_rst_hold");
        runCycle(4'h2, 1'b0, 1'b0, 1'b1, "add_rst_rel");
        for (int i = 0; i < 4; i++) runCycle(4'h2, 1'b0, 1'b0, 1'b1, "add_tail");

        // JZ with zf clear, then set; then JC and JMP
        for (int i = 0; i < 5; i++) runCycle(4'h8, 1'b1, 1'b0, 1'b1, "jz_zf0");
        for (int i = 0; i < 5; i++) runCycle(4'h8, 1'b0, 1'b1, 1'b1, "jz_zf1");
        for (int i = 0; i < 5; i++) runCycle(4'h7, 1'b1, 1'b0, 1'b1, "jc_cf1");
        for (int i = 0; i < 5; i++) runCycle(4'h6, 1'b0, 1'b0, 1'b1, "jmp");
        for (int i = 0; i < 5; i++) runCycle(4'h9, 1'b1, 1'b1, 1'b1, "undef");

        // Randomized opcodes, flags and occasional resets
        for (int i = 0; i < 600; i++)
            runCycle(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 15) != 0), "rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
